// File: rtl/apb_text_writer.sv
// APB write-only text writer: places characters into a COLS x ROWS
// character map (one 32-bit word per cell) and can fill the map with spaces.
module apb_text_writer #(
  parameter int APB_ADDR_WIDTH = 14,
  parameter int APB_DATA_WIDTH = 32,
  parameter int COLS           = 80,
  parameter int ROWS           = 30
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      char_valid_i,
  output logic                      char_ready_o,
  input  logic [7:0]                char_i,
  input  logic [7:0]                color_i,
  input  logic                      clear_i,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i,
  output logic [11:0]               cursor_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int CELLS = COLS * ROWS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CLR_SETUP, CLR_ACCESS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    color_q, color_d;
  logic [11:0]   clr_idx_q, clr_idx_d;
  logic          err_q, err_d;
  logic [11:0]   cursor;
  logic          unused_prdata;

  // Read data is never consumed by a write-only initiator.
  assign unused_prdata = ^apb_prdata_i;

  // Row index after a line feed or a line overflow; the last row wraps to the top.
  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
    return (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
  endfunction

  assign cursor       = 12'(int'(row_q) * COLS + int'(col_q));
  assign cursor_o     = cursor;
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;
  assign char_ready_o = (state_q == IDLE) && !clear_i;

  // Next-state logic and Moore-style APB outputs (zero outside transfer states).
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    char_d        = char_q;
    color_d       = color_q;
    clr_idx_d     = clr_idx_q;
    err_d         = err_q;
    apb_psel_o    = 1'b0;
    apb_penable_o = 1'b0;
    apb_pwrite_o  = 1'b0;
    apb_paddr_o   = '0;
    apb_pwdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d   = CLR_SETUP;
          clr_idx_d = '0;
        end else if (char_valid_i) begin
          if (char_i == 8'h0A) begin
            col_d = '0;
            row_d = next_row(row_q);
          end else if (char_i == 8'h0D) begin
            col_d = '0;
          end else begin
            char_d  = char_i;
            color_d = color_i;
            state_d = SETUP;
          end
        end
      end
      SETUP, ACCESS: begin
        apb_psel_o    = 1'b1;
        apb_penable_o = (state_q == ACCESS);
        apb_pwrite_o  = 1'b1;
        apb_paddr_o   = APB_ADDR_WIDTH'({cursor, 2'b00});
        apb_pwdata_o  = APB_DATA_WIDTH'({color_q, char_q});
        if (state_q == SETUP) begin
          state_d = ACCESS;
        end else if (apb_pready_i) begin
          state_d = IDLE;
          if (apb_pslverr_i) err_d = 1'b1;
          if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = next_row(row_q);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      CLR_SETUP, CLR_ACCESS: begin
        apb_psel_o    = 1'b1;
        apb_penable_o = (state_q == CLR_ACCESS);
        apb_pwrite_o  = 1'b1;
        apb_paddr_o   = APB_ADDR_WIDTH'({clr_idx_q, 2'b00});
        apb_pwdata_o  = APB_DATA_WIDTH'(32'h0000_0020);
        if (state_q == CLR_SETUP) begin
          state_d = CLR_ACCESS;
        end else if (apb_pready_i) begin
          if (apb_pslverr_i) err_d = 1'b1;
          if (clr_idx_q == 12'(CELLS - 1)) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
          end else begin
            state_d   = CLR_SETUP;
            clr_idx_d = clr_idx_q + 12'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      clr_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      clr_idx_q <= clr_idx_d;
      err_q     <= err_d;
    end
  end

  // Latched character payload; only observed while a transfer is in flight.
  always_ff @(posedge clk_i) begin
    char_q  <= char_d;
    color_q <= color_d;
  end

endmodule

// File: tb/tb_apb_text_writer.sv
// Self-checking bench for apb_text_writer: a transaction-level model of the
// character map predicts the APB transfers, cursor, busy/ready and error flag.
module tb_apb_text_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        char_valid_i = 1'b0;
  logic        char_ready_o;
  logic [7:0]  char_i = 8'h00;
  logic [7:0]  color_i = 8'h00;
  logic        clear_i = 1'b0;
  logic [13:0] apb_paddr_o;
  logic [31:0] apb_pwdata_o;
  logic        apb_pwrite_o;
  logic        apb_psel_o;
  logic        apb_penable_o;
  logic [31:0] apb_prdata_i = 32'hDEAD_BEEF;
  logic        apb_pready_i = 1'b0;
  logic        apb_pslverr_i = 1'b0;
  logic [11:0] cursor_o;
  logic        busy_o;
  logic        err_o;

  apb_text_writer #(.APB_ADDR_WIDTH(14), .APB_DATA_WIDTH(32), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .char_valid_i(char_valid_i), .char_ready_o(char_ready_o),
    .char_i(char_i), .color_i(color_i), .clear_i(clear_i),
    .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o), .apb_pwrite_o(apb_pwrite_o),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o), .apb_prdata_i(apb_prdata_i),
    .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i),
    .cursor_o(cursor_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave responder: pready after pw wait cycles of ACCESS, optional error.
  int   pw = 0;
  int   acc_n = 0;
  logic slv_mode = 1'b0;
  always @(posedge clk_i) begin
    #1;
    if (apb_psel_o && apb_penable_o) begin
      apb_pready_i  = (acc_n >= pw);
      apb_pslverr_i = slv_mode && apb_pready_i;
      acc_n++;
    end else begin
      acc_n         = 0;
      apb_pready_i  = 1'b0;
      apb_pslverr_i = 1'b0;
    end
  end

  // Model of the character map: a queue of expected transfers plus cursor/error.
  typedef struct {
    int          addr;
    logic [31:0] data;
    int          kind;  // 0 char, 1 clear cell, 2 last clear cell
  } xfer_t;

  xfer_t       q[$];
  xfer_t       f;
  int          m_cursor = 0;
  logic        m_err = 1'b0;
  logic        m_phase = 1'b0;
  logic        busy_e;
  logic        chk_en = 1'b0;
  int          xfer_cnt = 0;
  logic [31:0] last_addr = 0;
  logic [31:0] last_data = 0;

  always @(negedge clk_i) begin
    busy_e = (q.size() != 0);
    if (chk_en) begin
      chk("busy", busy_o, busy_e);
      chk("ready", char_ready_o, !busy_e && !clear_i);
      chk("cursor", cursor_o, m_cursor);
      chk("err", err_o, m_err);
      chk("psel", apb_psel_o, busy_e);
      if (busy_e) begin
        f = q[0];
        chk("penable", apb_penable_o, m_phase);
        chk("paddr", apb_paddr_o, f.addr);
        chk("pwdata", apb_pwdata_o, f.data);
        chk("pwrite", apb_pwrite_o, 1'b1);
      end else begin
        chk("penable_idle", apb_penable_o, 1'b0);
        chk("pwrite_idle", apb_pwrite_o, 1'b0);
        chk("paddr_idle", apb_paddr_o, 0);
        chk("pwdata_idle", apb_pwdata_o, 0);
      end
    end
    if (rst_i) begin
      q.delete();
      m_cursor = 0;
      m_err    = 1'b0;
      m_phase  = 1'b0;
    end else if (busy_e) begin
      if (!m_phase) begin
        m_phase = 1'b1;
      end else if (apb_pready_i) begin
        f         = q.pop_front();
        m_phase   = 1'b0;
        xfer_cnt++;
        last_addr = 32'(apb_paddr_o);
        last_data = apb_pwdata_o;
        if (apb_pslverr_i) m_err = 1'b1;
        if (f.kind == 0) m_cursor = (m_cursor + 1) % CELLS;
        else if (f.kind == 2) m_cursor = 0;
      end
    end else if (clear_i) begin
      for (int i = 0; i < CELLS; i++)
        q.push_back('{addr: i * 4, data: 32'h20, kind: (i == CELLS - 1) ? 2 : 1});
    end else if (char_valid_i) begin
      if (char_i == 8'h0A)      m_cursor = (((m_cursor / COLS) + 1) % ROWS) * COLS;
      else if (char_i == 8'h0D) m_cursor = (m_cursor / COLS) * COLS;
      else q.push_back('{addr: m_cursor * 4, data: {16'h0, color_i, char_i}, kind: 0});
    end
  end

  int lat;

  // Offer one character, then wait (bounded) until the writer is idle again.
  task automatic send(input logic [7:0] c, input logic [7:0] col, input int waits);
    int n;
    pw = waits;
    @(posedge clk_i); #1;
    char_valid_i = 1'b1; char_i = c; color_i = col;
    @(posedge clk_i); #1;
    char_valid_i = 1'b0;
    n = 0;
    while (busy_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    lat = n;
  endtask

  initial begin
    int n;
    int base;
    repeat (2) @(posedge clk_i);
    #1;
    chk_en = 1'b1;
    rst_i  = 1'b0;
    chk("rst_cursor", cursor_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", char_ready_o, 1);

    // 'A' at cell 0 with immediate pready
    send(8'h41, 8'h1F, 0);
    chk("A_addr", last_addr, 32'h0000);
    chk("A_data", last_data, 32'h0000_1F41);
    chk("A_lat", lat, 2);
    chk("A_cursor", cursor_o, 1);

    // Fill to cell 79, then 'B' with 3 wait states wraps the column
    for (int i = 0; i < 78; i++) send(8'h2E, 8'h07, 0);
    chk("c79", cursor_o, 79);
    send(8'h42, 8'h07, 3);
    chk("B_addr", last_addr, 32'h013C);
    chk("B_lat", lat, 5);
    chk("B_cursor", cursor_o, 80);

    // Move to the last cell and wrap the whole map
    for (int i = 0; i < 28; i++) send(8'h0A, 8'h00, 0);
    chk("lf_row29", cursor_o, 2320);
    for (int i = 0; i < 79; i++) send(8'h2E, 8'h07, 0);
    chk("c2399", cursor_o, 2399);
    send(8'h43, 8'h07, 0);
    chk("C_addr", last_addr, 32'h257C);
    chk("C_cursor", cursor_o, 0);

    // LF / CR handling
    send(8'h0A, 8'h00, 0);
    send(8'h0A, 8'h00, 0);
    for (int i = 0; i < 5; i++) send(8'h2E, 8'h07, 0);
    chk("c165", cursor_o, 165);
    send(8'h0A, 8'h00, 0);
    chk("LF_lat", lat, 0);
    chk("LF_cursor", cursor_o, 240);
    send(8'h58, 8'h07, 1);
    chk("X_cursor", cursor_o, 241);
    send(8'h0D, 8'h00, 0);
    chk("CR_cursor", cursor_o, 240);

    // Slave error is sticky and the cursor still advances
    slv_mode = 1'b1;
    send(8'h45, 8'h0C, 2);
    slv_mode = 1'b0;
    chk("slverr_err", err_o, 1);
    chk("slverr_cursor", cursor_o, 241);
    send(8'h46, 8'h0C, 0);
    chk("err_sticky", err_o, 1);
    chk("after_err_cursor", cursor_o, 242);

    // Clear with a competing character request
    pw   = 0;
    base = xfer_cnt;
    @(posedge clk_i); #1;
    clear_i = 1'b1; char_valid_i = 1'b1; char_i = 8'h5A; color_i = 8'h07;
    @(posedge clk_i); #1;
    clear_i = 1'b0; char_valid_i = 1'b0;
    n = 0;
    while (busy_o && n < 6000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 6000) chk("clear_timeout", 1, 0);
    chk("clear_count", xfer_cnt - base, 2400);
    chk("clear_last_addr", last_addr, 32'h257C);
    chk("clear_last_data", last_data, 32'h20);
    chk("clear_cursor", cursor_o, 0);
    chk("clear_err", err_o, 1);

    // Reset in the middle of ACCESS abandons the transfer
    pw = 50;
    @(posedge clk_i); #1;
    char_valid_i = 1'b1; char_i = 8'h47; color_i = 8'h07;
    @(posedge clk_i); #1;
    char_valid_i = 1'b0;
    n = 0;
    while (!(apb_psel_o && apb_penable_o) && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 10) chk("access_timeout", 1, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    pw    = 0;
    chk("rst_psel", apb_psel_o, 0);
    chk("rst_mid_err", err_o, 0);
    chk("rst_mid_cursor", cursor_o, 0);
    chk("rst_mid_ready", char_ready_o, 1);
    repeat (3) @(posedge clk_i);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_text_writer.md
APB_TEXT_WRITER -- requirements
Module: apb_text_writer

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- APB_ADDR_WIDTH, 14, APB address width.
- APB_DATA_WIDTH, 32, APB data width.
- COLS, 80, text columns.
- ROWS, 30, text rows.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk_i, in, 1, sole clock.
- rst_i, in, 1, reset, synchronous, active-high.
- char_valid_i, in, 1, character request valid.
- char_ready_o, out, 1, character request accepted.
- char_i, in, 8, character code.
- color_i, in, 8, color attribute.
- clear_i, in, 1, screen clear request (level, sampled in IDLE).
- apb_paddr_o, out, APB_ADDR_WIDTH, byte address.
- apb_pwdata_o, out, APB_DATA_WIDTH, write data.
- apb_pwrite_o, out, 1, write strobe.
- apb_psel_o, out, 1, select.
- apb_penable_o, out, 1, enable.
- apb_prdata_i, in, APB_DATA_WIDTH, read data (unused).
- apb_pready_i, in, 1, slave ready.
- apb_pslverr_i, in, 1, slave error.
- cursor_o, out, 12, current cell index, row*COLS+col.
- busy_o, out, 1, high whenever state is not IDLE.
- err_o, out, 1, sticky slave-error flag.

Function
REQ-003 The block SHALL be an APB write-only initiator that fills a COLS x ROWS character map; cell n SHALL be at byte address n*4, with data {16'b0, color, char} (color in [15:8], char in [7:0]).
REQ-004 The FSM SHALL have states IDLE, SETUP, ACCESS, CLR_SETUP, CLR_ACCESS.
REQ-005 char_ready_o SHALL be 1 only in IDLE with clear_i=0; a character is accepted on char_valid_i & char_ready_o.
REQ-006 In IDLE, clear_i=1 SHALL take priority over char_valid_i and move the FSM to CLR_SETUP with clear index 0.
REQ-007 An accepted char 0x0A (LF) SHALL issue no APB transfer: col=0; row=row+1, or row=0 when row=ROWS-1; the FSM stays in IDLE.
REQ-008 An accepted char 0x0D (CR) SHALL issue no APB transfer: col=0, row unchanged; the FSM stays in IDLE.
REQ-009 Any other accepted char SHALL latch char_i and color_i and go to SETUP on the next cycle.
REQ-010 In SETUP/CLR_SETUP: psel=1, penable=0, pwrite=1, and paddr/pwdata valid; the next state is the matching ACCESS state unconditionally.
REQ-011 In ACCESS/CLR_ACCESS: psel=1 and penable=1, and paddr/pwdata/pwrite SHALL be held stable until apb_pready_i=1; wait states are unbounded.
REQ-012 On ACCESS completion (pready=1), the FSM SHALL return to IDLE and advance the cursor: col+1; at col=COLS-1, col=0 and row advances as in REQ-007 (ROWS-1 wraps to 0; cell 2399 wraps to 0).
REQ-013 A clear SHALL write data 0x0000_0020 to cells 0..COLS*ROWS-1 in ascending order, with one SETUP+ACCESS per cell and no idle cycle between cells.
REQ-014 Completing the last cell of a clear SHALL set cursor to 0 (row=0, col=0) and return to IDLE.
REQ-015 Minimum latency SHALL be: char accepted at cycle t -> SETUP at t+1 -> ACCESS at t+2 -> with pready at t+2, IDLE and char_ready_o=1 at t+3.
REQ-016 Outside SETUP/ACCESS states, psel, penable and pwrite SHALL be 0, and paddr/pwdata SHALL be 0.
REQ-017 apb_pslverr_i sampled with pready in an ACCESS state SHALL set err_o; the transfer SHALL still count as complete, and the cursor advances.
REQ-018 err_o SHALL clear only on reset.
REQ-019 cursor_o SHALL update in the cycle after the completing or LF/CR event.
REQ-020 apb_prdata_i SHALL be ignored.

Reset
REQ-021 rst_i sampled high SHALL force state IDLE, row=col=0, cursor_o=0, err_o=0, busy_o=0, and all APB outputs 0 on the following edge.
REQ-022 A reset during SETUP or ACCESS SHALL abandon the transfer, with psel dropping at the next edge; the pending character is lost.
REQ-023 char_ready_o SHALL be 1 in the first cycle after reset release if clear_i=0.

Verification
REQ-024 Char 'A' (0x41), color 0x1F at cursor 0, pready immediate -> one transfer with paddr=0x0000, pwdata=0x0000_1F41, 2-cycle APB phase, then cursor_o=1.
REQ-025 Cursor 79, char 0x42, pready after 3 wait cycles -> paddr=0x013C, signals held over 3 waits, then cursor_o=80.
REQ-026 Cursor 2399, char 0x43 -> paddr=0x257C, then cursor_o=0.
REQ-027 Cursor 165: LF -> cursor_o=240 with no psel; then CR after 'X' -> cursor_o=240.
REQ-028 Assert clear_i with char_valid_i also high -> 2400 writes, addresses 0x0000..0x257C step 4, all data 0x20; char_ready_o=0 throughout; final cursor_o=0.
REQ-029 pslverr_i=1 on a completing transfer -> err_o=1 and stays set; cursor advances; rst_i mid-ACCESS -> psel=0 on the next edge and err_o=0.
